// File: rtl/fft_burst_ctrl_pkg.sv
// Shared types and constants for the burst-mode FFT frame controller.
package fft_burst_ctrl_pkg;

    // Harmonics captured per frame (fundamental plus 2..5).
    localparam int NUM_HARM = 5;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitOut,
        StUnload,
        StDone,
        StGap
    } state_t;

    // Harmonic bins at or above this index are past Nyquist and are not captured.
    function automatic int unsigned fft_half(input int unsigned len);
        return len / 2;
    endfunction

endpackage

// File: rtl/fft_burst_ctrl_harm_capture.sv
// Output-bin counter, harmonic bin table and |X|^2 shadow registers.
module fft_burst_ctrl_harm_capture
    import fft_burst_ctrl_pkg::*;
#(
    parameter int unsigned FFT_LEN = 1024,
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned AMP_W   = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CNT_W-1:0]          fund,
    input  logic                      clr,
    input  logic                      en,
    input  logic [AMP_W-1:0]          amp,
    output logic [CNT_W-1:0]          bcnt,
    output logic [NUM_HARM*AMP_W-1:0] shadows,
    output logic [NUM_HARM-1:0]       range_bits
);

    // Three guard bits hold 5*fund without wrapping, so out-of-range bins are never aliased.
    localparam int unsigned HW       = CNT_W + 3;
    localparam int unsigned FFT_HALF = fft_half(FFT_LEN);

    logic [HW-1:0]    harm   [NUM_HARM];
    logic [AMP_W-1:0] shadow [NUM_HARM];

    // Accumulator chain h_k = h_(k-1) + fund; settles a few cycles after fund is latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_HARM; k++) harm[k] <= '0;
        end else begin
            harm[0] <= {3'b000, fund};
            for (int k = 1; k < NUM_HARM; k++) harm[k] <= harm[k-1] + {3'b000, fund};
        end
    end

    // Range flags and flattened shadow bus.
    always_comb begin
        range_bits = '0;
        shadows    = '0;
        for (int k = 0; k < NUM_HARM; k++) begin
            range_bits[k]              = (harm[k] >= HW'(FFT_HALF));
            shadows[k*AMP_W +: AMP_W] = shadow[k];
        end
    end

    // Count output bins and grab amp when the bin matches an in-range harmonic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
            for (int k = 0; k < NUM_HARM; k++) shadow[k] <= '0;
        end else if (clr) begin
            bcnt <= '0;
            for (int k = 0; k < NUM_HARM; k++) shadow[k] <= '0;
        end else if (en) begin
            bcnt <= bcnt + CNT_W'(1);
            for (int k = 0; k < NUM_HARM; k++) begin
                if (!range_bits[k] && (harm[k] == {3'b000, bcnt})) shadow[k] <= amp;
            end
        end
    end

endmodule

// File: rtl/fft_burst_ctrl.sv
// Burst-mode FFT frame sequencer: sink framing, output-bin tracking, harmonic publish.
module fft_burst_ctrl
    import fft_burst_ctrl_pkg::*;
#(
    parameter int unsigned FFT_LEN = 1024,
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned AMP_W   = 24,
    parameter int unsigned GAP_CYC = 16,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic               cont_mode,
    input  logic [CNT_W-1:0]   fund_bin,
    input  logic               sink_ready,
    output logic               sink_valid,
    output logic               sink_sop,
    output logic               sink_eop,
    input  logic               source_valid,
    input  logic               source_sop,
    input  logic               source_eop,
    input  logic [AMP_W-1:0]   amp,
    output logic [AMP_W-1:0]   amp_1,
    output logic [AMP_W-1:0]   amp_2,
    output logic [AMP_W-1:0]   amp_3,
    output logic [AMP_W-1:0]   amp_4,
    output logic [AMP_W-1:0]   amp_5,
    output logic [4:0]         range_err,
    output logic               catch_flag,
    output logic               done,
    output logic               err
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    state_t                    state;
    logic [CNT_W-1:0]          scnt;
    logic [WD_W-1:0]           wd;
    logic [GAP_W-1:0]          gcnt;
    logic [CNT_W-1:0]          fund;
    logic [CNT_W-1:0]          bcnt;
    logic [NUM_HARM*AMP_W-1:0] shadows;
    logic [NUM_HARM-1:0]       range_bits;
    logic                      cap_clr;
    logic                      cap_en;

    // Shadows are wiped while loading; the sop beat seen in WAIT_OUT is bin 0.
    always_comb begin
        cap_clr = (state == StLoad);
        cap_en  = source_valid && ((state == StUnload) || ((state == StWaitOut) && source_sop));
    end

    fft_burst_ctrl_harm_capture #(
        .FFT_LEN (FFT_LEN),
        .CNT_W   (CNT_W),
        .AMP_W   (AMP_W)
    ) u_capture (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .fund       (fund),
        .clr        (cap_clr),
        .en         (cap_en),
        .amp        (amp),
        .bcnt       (bcnt),
        .shadows    (shadows),
        .range_bits (range_bits)
    );

    // Frame FSM with all outputs registered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= StIdle;
            scnt       <= '0;
            wd         <= '0;
            gcnt       <= '0;
            fund       <= '0;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            amp_1      <= '0;
            amp_2      <= '0;
            amp_3      <= '0;
            amp_4      <= '0;
            amp_5      <= '0;
            range_err  <= '0;
            catch_flag <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        fund       <= fund_bin;
                        state      <= StLoad;
                        scnt       <= '0;
                        sink_valid <= 1'b1;
                        sink_sop   <= 1'b1;
                        catch_flag <= 1'b1;
                    end
                end
                StLoad: begin
                    if (sink_ready) begin
                        scnt     <= scnt + CNT_W'(1);
                        sink_sop <= 1'b0;
                        if (sink_eop) begin
                            state      <= StWaitOut;
                            sink_valid <= 1'b0;
                            sink_eop   <= 1'b0;
                            wd         <= '0;
                        end else begin
                            sink_eop <= (scnt == CNT_W'(FFT_LEN - 2));
                        end
                    end
                end
                StWaitOut: begin
                    if (source_valid && source_sop) begin
                        state <= StUnload;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        err        <= 1'b1;
                        state      <= StIdle;
                        catch_flag <= 1'b0;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                StUnload: begin
                    if (source_valid) begin
                        if (source_sop || (source_eop && (bcnt != CNT_W'(FFT_LEN - 1)))) begin
                            err        <= 1'b1;
                            state      <= StIdle;
                            catch_flag <= 1'b0;
                        end else if (source_eop) begin
                            // Final bin is never an in-range harmonic, so shadows are complete here.
                            state      <= StDone;
                            done       <= 1'b1;
                            catch_flag <= 1'b0;
                            amp_1      <= shadows[0*AMP_W +: AMP_W];
                            amp_2      <= shadows[1*AMP_W +: AMP_W];
                            amp_3      <= shadows[2*AMP_W +: AMP_W];
                            amp_4      <= shadows[3*AMP_W +: AMP_W];
                            amp_5      <= shadows[4*AMP_W +: AMP_W];
                            range_err  <= range_bits;
                        end
                    end
                end
                StDone: begin
                    gcnt  <= '0;
                    state <= cont_mode ? StGap : StIdle;
                end
                StGap: begin
                    if (!cont_mode) begin
                        state <= StIdle;
                    end else if (gcnt == GAP_W'(GAP_CYC - 1)) begin
                        state      <= StLoad;
                        scnt       <= '0;
                        sink_valid <= 1'b1;
                        sink_sop   <= 1'b1;
                        catch_flag <= 1'b1;
                    end else begin
                        gcnt <= gcnt + GAP_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_burst_ctrl.sv
// Directed bench for fft_burst_ctrl with a scoreboard of expected harmonic powers.
module tb_fft_burst_ctrl;

    localparam int FFT_LEN = 1024;
    localparam int CNT_W   = 10;
    localparam int AMP_W   = 24;
    localparam int GAP_CYC = 16;
    localparam int TIMEOUT = 4096;

    typedef struct packed {
        logic [5*AMP_W-1:0] amps;
        logic [4:0]         rng;
    } exp_t;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cont_mode = 1'b0;
    logic [CNT_W-1:0] fund_bin = '0;
    logic             sink_ready = 1'b1;
    logic             sink_valid, sink_sop, sink_eop;
    logic             source_valid = 1'b0;
    logic             source_sop = 1'b0;
    logic             source_eop = 1'b0;
    logic [AMP_W-1:0] amp = '0;
    logic [AMP_W-1:0] amp_1, amp_2, amp_3, amp_4, amp_5;
    logic [4:0]       range_err;
    logic             catch_flag, done, err;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t last_exp = '0;

    always #5 sys_clk = ~sys_clk;

    fft_burst_ctrl u_dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .cont_mode    (cont_mode),
        .fund_bin     (fund_bin),
        .sink_ready   (sink_ready),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .amp          (amp),
        .amp_1        (amp_1),
        .amp_2        (amp_2),
        .amp_3        (amp_3),
        .amp_4        (amp_4),
        .amp_5        (amp_5),
        .range_err    (range_err),
        .catch_flag   (catch_flag),
        .done         (done),
        .err          (err)
    );

    wire [5*AMP_W-1:0] amps_cat = {amp_5, amp_4, amp_3, amp_2, amp_1};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: harmonic k sits at bin k*fund; source amp is mult*bin+off.
    function automatic exp_t model(input int fund, input int mult, input int off);
        exp_t e;
        e = '0;
        for (int k = 1; k <= 5; k++) begin
            int h;
            h = k * fund;
            if (h >= FFT_LEN / 2) e.rng[k-1] = 1'b1;
            else e.amps[(k-1)*AMP_W +: AMP_W] = AMP_W'(mult * h + off);
        end
        return e;
    endfunction

    task automatic start_frame(input int f);
        @(negedge sys_clk);
        fund_bin = CNT_W'(f);
        start    = 1'b1;
    endtask

    // last_bin < 0: no FFT output at all (watchdog case). exp_wait: cycles until sink_valid.
    task automatic do_frame(input int fund, input int mult, input int off, input bit gaps,
                            input int last_bin, input int exp_wait, input bit exp_done);
        exp_t e;
        int   cnt, acc, nsop, neop, lowcnt;
        bit   seen;
        if (exp_done) sb.push_back(model(fund, mult, off));
        cnt  = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge sys_clk);
            start = 1'b0;
            cnt++;
            if (cnt == 1) check("done_single_cycle", done, 0);
            if (sink_valid) seen = 1;
        end
        check("sink_valid_seen", seen, 1);
        if (!seen) return;
        check("cycles_to_sink_valid", cnt, exp_wait);
        check("first_beat_sop", sink_sop, 1);
        check("catch_in_load", catch_flag, 1);

        acc = 0; nsop = 0; neop = 0; lowcnt = 0; seen = 0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            if (i > 0) @(negedge sys_clk);
            if (sink_valid && sink_ready) begin
                acc++;
                nsop += int'(sink_sop);
                neop += int'(sink_eop);
                seen = sink_eop;
                if (gaps && (acc % 100 == 0)) lowcnt = 3;
            end
            if (lowcnt > 0) begin
                sink_ready = 1'b0;
                lowcnt--;
            end else begin
                sink_ready = 1'b1;
            end
        end
        sink_ready = 1'b1;
        check("accepted_samples", acc, FFT_LEN);
        check("sop_beats", nsop, 1);
        check("eop_beats", neop, 1);
        @(negedge sys_clk);
        check("valid_drop_after_eop", sink_valid, 0);
        check("catch_in_wait", catch_flag, 1);

        if (last_bin < 0) begin
            // TIMEOUT cycles in WAIT_OUT, err visible on the cycle after.
            cnt  = 1;
            seen = 0;
            for (int i = 0; i < 5000 && !seen; i++) begin
                if (err) seen = 1;
                else begin
                    @(negedge sys_clk);
                    cnt++;
                end
            end
            check("timeout_err_seen", seen, 1);
            check("timeout_cycles", cnt, TIMEOUT + 1);
            check("catch_after_timeout", catch_flag, 0);
            check("done_on_timeout", done, 0);
            check("amps_hold_timeout", amps_cat, last_exp.amps);
            @(negedge sys_clk);
            check("err_single_cycle", err, 0);
            return;
        end

        repeat (3) @(negedge sys_clk);
        for (int b = 0; b <= last_bin; b++) begin
            if (b % 256 == 128) begin
                @(negedge sys_clk);
                source_valid = 1'b0;
            end
            @(negedge sys_clk);
            source_valid = 1'b1;
            source_sop   = (b == 0);
            source_eop   = (b == last_bin);
            amp          = AMP_W'(mult * b + off);
        end
        @(negedge sys_clk);
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        check("done_pulse", done, exp_done);
        check("err_pulse", err, !exp_done);
        check("catch_after_frame", catch_flag, 0);
        if (done && sb.size() > 0) begin
            e = sb.pop_front();
            check("amps", amps_cat, e.amps);
            check("range_err", range_err, e.rng);
            last_exp = e;
        end else begin
            check("amps_hold", amps_cat, last_exp.amps);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_sink_valid", sink_valid, 0);
        check("rst_catch", catch_flag, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_amps", amps_cat, 0);
        check("rst_range", range_err, 0);
        sys_rst_n = 1'b1;

        // Basic frame, fund 10, amp = 3*bin.
        start_frame(10);
        do_frame(10, 3, 0, 0, FFT_LEN - 1, 1, 1);

        // fund 150 with backpressure: harmonics 4 and 5 out of range.
        start_frame(150);
        do_frame(150, 3, 0, 1, FFT_LEN - 1, 1, 1);

        // Early source_eop at bin 700.
        start_frame(20);
        do_frame(20, 3, 0, 0, 700, 1, 0);

        // No output from the core: watchdog.
        start_frame(30);
        do_frame(30, 3, 0, 0, -1, 1, 0);

        // Continuous mode for three frames.
        cont_mode = 1'b1;
        start_frame(7);
        do_frame(7, 3, 0, 0, FFT_LEN - 1, 1, 1);
        do_frame(7, 5, 0, 0, FFT_LEN - 1, GAP_CYC + 1, 1);
        do_frame(7, 7, 0, 0, FFT_LEN - 1, GAP_CYC + 1, 1);
        cont_mode = 1'b0;
        repeat (30) @(negedge sys_clk);
        check("idle_after_cont", sink_valid, 0);
        check("idle_catch", catch_flag, 0);

        // fund 0: every harmonic takes the DC bin.
        start_frame(0);
        do_frame(0, 3, 99, 0, FFT_LEN - 1, 1, 1);

        // Reset in the middle of LOAD.
        start_frame(10);
        repeat (50) @(negedge sys_clk);
        start = 1'b0;
        check("load_active", sink_valid, 1);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_sink_valid", sink_valid, 0);
        check("midrst_catch", catch_flag, 0);
        check("midrst_amps", amps_cat, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        last_exp = '0;
        start_frame(10);
        do_frame(10, 3, 0, 0, FFT_LEN - 1, 1, 1);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
